mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM that sequences the MIPS datapath one instruction at a time.
//  Accepts an instruction over a valid/ready handshake and holds it in an internal IR.
//  Drives IR plus RegDst/ALUSrc/ALUCtrl/MemRead/MemWrite/MemtoReg/RegWrite through DECODE/EXEC/MEM/WB.
//  Regfile and memory write on the rising edge of their enables, so every write enable is a 1-cycle registered pulse.
// PARAMETERS
//  MEM_WAIT  0   extra cycles spent in MEM before leaving it (0..15)
//  CNT_W     32  width of the performance counters (MIPS_PERF_CNT_EN only)
// PORTS
//  clk         in   1   single clock; all state changes on rising edge
//  resetN      in   1   synchronous, active-low reset
//  instrValid  in   1   upstream offers instrIn
//  instrIn     in   32  instruction word
//  instrReady  out  1   high only in IDLE; accept = instrValid & instrReady
//  instrOut    out  32  held IR, wired to datapath instruction input
//  RegDst      out  1   0: write rt [20:16]; 1: write rd [15:11]
//  ALUSrc      out  1   0: readData2; 1: sign-extended imm
//  ALUCtrl     out  4   0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor
//  MemRead     out  1   memory read enable
//  MemWrite    out  1   memory write pulse
//  MemtoReg    out  1   0: ALU result; 1: memory data to regfile
//  RegWrite    out  1   regfile write pulse
//  done        out  1   1-cycle pulse when instruction retires
//  illegal     out  1   1-cycle pulse on unsupported opcode/funct
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, IR=0, all 1-bit outputs 0, ALUCtrl=0010.
//  - States: IDLE -> DECODE -> EXEC -> {MEM, WB} -> IDLE.
//  - IDLE: instrReady=1. On accept, IR<=instrIn, go to DECODE. Otherwise stay.
//  - DECODE: set RegDst, ALUSrc, ALUCtrl, MemtoReg from IR; they stay constant until return to IDLE.
//  - Unsupported op in DECODE: pulse illegal, go to IDLE, no write pulse.
//  - Supported ops:
//      R-type op=000000: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
//        RegDst=1, ALUSrc=0, MemtoReg=0.
//      addi op=0x08: RegDst=0, ALUSrc=1, ALUCtrl=add.
//      lw op=0x23: RegDst=0, ALUSrc=1, add, MemtoReg=1.
//      sw op=0x2B: ALUSrc=1, add.
//  - EXEC (1 cycle): ALU settles. Go to MEM for lw/sw, otherwise to WB.
//  - MEM: stay 1+MEM_WAIT cycles, counted by a 4-bit counter cleared on entry.
//      lw: MemRead=1 for all of MEM and WB.
//      sw: MemWrite=1 only in the last MEM cycle; done pulses in that same cycle; then IDLE.
//  - WB (1 cycle): RegWrite=1 and done=1, then IDLE. RegWrite/MemWrite never high two consecutive cycles.
//  - Latency from accept to done: R-type/addi 3 cycles; lw 4+MEM_WAIT; sw 3+MEM_WAIT; illegal pulse 1 cycle.
//  - Back-to-back: after done, the next accept comes no earlier than the following cycle (IDLE).
//  - instrValid while busy is ignored; upstream holds instrIn until accepted.
//  - resetN=0 in any state: next edge forces the reset values.
//      An in-flight instruction is dropped with no write pulse, done or illegal.
//  - A write to register 0 is not suppressed; the datapath owns $zero semantics.
// CONFIGURATION
//  MIPS_PERF_CNT_EN defined:
//    - adds outputs retiredCnt[CNT_W-1:0] (+1 per done) and cycleCnt[CNT_W-1:0] (+1 per clk out of reset).
//    - both counters clear on reset and wrap modulo 2^CNT_W; illegal does not increment retiredCnt.
//  MIPS_PERF_CNT_EN undefined: neither port nor its counter logic exists; all other behaviour identical.
// STRUCTURE
//  mips_ctrl_pkg holds:
//    - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW)
//    - funct constants
//    - ALUCtrl encodings (ALU_AND..ALU_NOR)
//    - state enum (ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB)
//  Sub-module mips_alu_decoder: combinational {opcode,funct} -> {ALUCtrl, legal}.
//  The FSM, IR, MEM wait counter and perf counters stay in this module.
// TESTING
//  1. Reset held 3 cycles mid-lw -> all outputs 0, ALUCtrl=0010, instrReady=1 after release, no write pulse.
//  2. add $3,$1,$2 (0x00221820) -> RegDst=1, ALUCtrl=0010, single RegWrite pulse and done 3 cycles after accept.
//  3. lw $5,4($0) (0x8C050004), MEM_WAIT=2 -> MemRead high 4 cycles, MemtoReg=1, RegWrite+done at cycle 6.
//  4. sw $5,8($0) (0xAC050008) -> one MemWrite pulse, RegWrite never high, done at cycle 3.
//  5. Opcode 0x3F (0xFC000000) -> illegal pulse cycle 1, no writes, instrReady=1 next cycle.
//  6. Back-to-back slt/nor with instrValid held high -> second accept in the cycle after the first done.
//     With MIPS_PERF_CNT_EN defined, retiredCnt=2.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants and types for the multi-cycle MIPS control FSM.
//   Holds the opcode/funct constants, the ALUCtrl encodings, the FSM state enum
//   and the packed datapath-control payload registered at instruction accept.
package mips_ctrl_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned WAIT_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    // Datapath steering held constant from accept until the next accept.
    typedef struct packed {
        logic             reg_dst;
        logic             alu_src;
        logic [ALU_W-1:0] alu_ctrl;
        logic             mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{reg_dst: 1'b0, alu_src: 1'b0,
                                     alu_ctrl: ALU_ADD, mem_to_reg: 1'b0};

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational {opcode, funct} -> {ALUCtrl, legal}.
//   opcode_i    in   6  instruction [31:26]
//   funct_i     in   6  instruction [5:0]
//   alu_ctrl_c  out  4  ALU operation (add for I-type and unsupported ops)
//   legal_c     out  1  opcode/funct combination is supported
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [ALU_W-1:0]   alu_ctrl_c,
    output logic               legal_c
);

    always_comb begin
        alu_ctrl_c = ALU_ADD;
        legal_c    = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                legal_c = 1'b1;
                case (funct_i)
                    FN_ADD:  alu_ctrl_c = ALU_ADD;
                    FN_SUB:  alu_ctrl_c = ALU_SUB;
                    FN_AND:  alu_ctrl_c = ALU_AND;
                    FN_OR:   alu_ctrl_c = ALU_OR;
                    FN_NOR:  alu_ctrl_c = ALU_NOR;
                    FN_SLT:  alu_ctrl_c = ALU_SLT;
                    default: legal_c    = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: legal_c = 1'b1;
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle control FSM sequencing the MIPS datapath
//   one instruction at a time (IDLE -> DECODE -> EXEC -> {MEM, WB} -> IDLE).
//   clk, resetN (sync, active-low); instrValid/instrIn/instrReady accept handshake;
//   instrOut held IR; RegDst/ALUSrc/ALUCtrl/MemtoReg steering; MemRead level;
//   MemWrite/RegWrite/done/illegal one-cycle pulses. All outputs registered.
//   Optional MIPS_PERF_CNT_EN adds retiredCnt/cycleCnt performance counters.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
`ifdef MIPS_PERF_CNT_EN
   ,parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              instrValid,
    input  logic [WORD_W-1:0] instrIn,
    output logic              instrReady,
    output logic [WORD_W-1:0] instrOut,
    output logic              RegDst,
    output logic              ALUSrc,
    output logic [ALU_W-1:0]  ALUCtrl,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              done,
    output logic              illegal
`ifdef MIPS_PERF_CNT_EN
   ,output logic [CNT_W-1:0]  retiredCnt,
    output logic [CNT_W-1:0]  cycleCnt
`endif
);

    localparam logic [WAIT_W-1:0] MEM_LAST = WAIT_W'(MEM_WAIT);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ready_q, ready_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              reg_write_q, reg_write_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic [OP_W-1:0]   in_op;
    logic [ALU_W-1:0]  dec_alu_c;
    logic              dec_legal_c;
    ctrl_t             dec_ctrl_c;
    logic              is_lw, is_sw;
    logic [WAIT_W-1:0] wait_inc;

    assign in_op    = instrIn[WORD_W-1 -: OP_W];
    assign is_lw    = (ir_q[WORD_W-1 -: OP_W] == OP_LW);
    assign is_sw    = (ir_q[WORD_W-1 -: OP_W] == OP_SW);
    assign wait_inc = wait_q + WAIT_W'(1);

    // Decode straight off instrIn so steering is valid from the DECODE cycle.
    mips_alu_decoder u_alu_dec (
        .opcode_i   (in_op),
        .funct_i    (instrIn[FUNCT_W-1:0]),
        .alu_ctrl_c (dec_alu_c),
        .legal_c    (dec_legal_c)
    );

    always_comb begin
        dec_ctrl_c.reg_dst    = dec_legal_c && (in_op == OP_RTYPE);
        dec_ctrl_c.alu_src    = dec_legal_c && (in_op != OP_RTYPE);
        dec_ctrl_c.alu_ctrl   = dec_alu_c;
        dec_ctrl_c.mem_to_reg = dec_legal_c && (in_op == OP_LW);
    end

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ctrl_d      = ctrl_q;
        wait_d      = wait_q;
        ready_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (instrValid && ready_q) begin
                    ready_d   = 1'b0;
                    ir_d      = instrIn;
                    ctrl_d    = dec_ctrl_c;
                    illegal_d = ~dec_legal_c;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (illegal_q) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_lw || is_sw) begin
                    state_d     = ST_MEM;
                    wait_d      = '0;
                    mem_read_d  = is_lw;
                    mem_write_d = is_sw && (MEM_LAST == '0);
                    done_d      = is_sw && (MEM_LAST == '0);
                end else begin
                    state_d     = ST_WB;
                    reg_write_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            ST_MEM: begin
                mem_read_d = is_lw;
                if (wait_q == MEM_LAST) begin
                    if (is_lw) begin
                        state_d     = ST_WB;
                        reg_write_d = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_inc;
                    // sw writes and retires in the final MEM cycle.
                    mem_write_d = is_sw && (wait_inc == MEM_LAST);
                    done_d      = is_sw && (wait_inc == MEM_LAST);
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            ctrl_q      <= CTRL_RESET;
            wait_q      <= '0;
            ready_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ctrl_q      <= ctrl_d;
            wait_q      <= wait_d;
            ready_q     <= ready_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
        end
    end

    assign instrReady = ready_q;
    assign instrOut   = ir_q;
    assign RegDst     = ctrl_q.reg_dst;
    assign ALUSrc     = ctrl_q.alu_src;
    assign ALUCtrl    = ctrl_q.alu_ctrl;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign RegWrite   = reg_write_q;
    assign done       = done_q;
    assign illegal    = illegal_q;

`ifdef MIPS_PERF_CNT_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] cycle_q;

    // retiredCnt steps in the same edge that raises done.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (done_d) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign retiredCnt = retired_q;
    assign cycleCnt   = cycle_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed bench for mips_multicycle_ctrl (MEM_WAIT=2).
//   Expected retire behaviour is queued at drive time and compared when the DUT
//   pulses done/illegal. Define MIPS_PERF_CNT_EN to also check the counters.
module tb_mips_multicycle_ctrl;

    localparam int unsigned MEM_WAIT = 2;
`ifdef MIPS_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        instrValid;
    logic [31:0] instrIn;
    logic        instrReady;
    logic [31:0] instrOut;
    logic        RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, done, illegal;
    logic [3:0]  ALUCtrl;
`ifdef MIPS_PERF_CNT_EN
    logic [CNT_W-1:0] retiredCnt, cycleCnt;
`endif

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(
        .MEM_WAIT (MEM_WAIT)
`ifdef MIPS_PERF_CNT_EN
       ,.CNT_W    (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .instrValid (instrValid),
        .instrIn    (instrIn),
        .instrReady (instrReady),
        .instrOut   (instrOut),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .ALUCtrl    (ALUCtrl),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .done       (done),
        .illegal    (illegal)
`ifdef MIPS_PERF_CNT_EN
       ,.retiredCnt (retiredCnt),
        .cycleCnt   (cycleCnt)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        int          lat;
        int          mem_rd;
        int          mem_wr;
        int          reg_wr;
        logic        reg_dst;
        logic        alu_src;
        logic [3:0]  alu;
        logic        m2r;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   passed  = 0;
    int   retired = 0;
    int   live    = 0;

    // Reference behaviour of one instruction, straight from the ISA table.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        e.instr = ins;   e.legal = 1'b1;  e.lat = 3;
        e.mem_rd = 0;    e.mem_wr = 0;    e.reg_wr = 1;
        e.reg_dst = 1'b0; e.alu_src = 1'b0; e.alu = 4'b0010; e.m2r = 1'b0;
        case (op)
            6'h00: begin
                e.reg_dst = 1'b1;
                case (fn)
                    6'h20:   e.alu = 4'b0010;
                    6'h22:   e.alu = 4'b0110;
                    6'h24:   e.alu = 4'b0000;
                    6'h25:   e.alu = 4'b0001;
                    6'h27:   e.alu = 4'b1100;
                    6'h2A:   e.alu = 4'b0111;
                    default: e.legal = 1'b0;
                endcase
            end
            6'h08: e.alu_src = 1'b1;
            6'h23: begin
                e.alu_src = 1'b1; e.m2r = 1'b1;
                e.lat = 4 + MEM_WAIT; e.mem_rd = 2 + MEM_WAIT;
            end
            6'h2B: begin
                e.alu_src = 1'b1; e.lat = 3 + MEM_WAIT;
                e.mem_wr = 1; e.reg_wr = 0;
            end
            default: e.legal = 1'b0;
        endcase
        if (!e.legal) begin
            e.lat = 1;
            e.reg_wr = 0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!resetN) begin
            live = 0;
            retired = 0;
        end else begin
            live++;
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] flags();
        return 32'({instrReady, RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, done, illegal});
    endfunction

    // Issue one instruction and follow it to retirement; hold keeps instrValid
    // high throughout and offers nxt as soon as this one retires.
    task automatic run(input logic [31:0] ins, input bit hold, input logic [31:0] nxt);
        exp_t       got;
        int         n, rw, mw, mr;
        bit         fin;
        logic       s_dst, s_src, s_m2r;
        logic [3:0] s_alu;
        check("ready_before", 32'(instrReady), 32'd1);
        instrIn    = ins;
        instrValid = 1'b1;
        sb.push_back(model(ins));
        tick();
        n = 1;
        if (!hold) instrValid = 1'b0;
        check("accepted", 32'(instrReady), 32'd0);
        check("ir", instrOut, ins);
        s_dst = RegDst; s_src = ALUSrc; s_alu = ALUCtrl; s_m2r = MemtoReg;
        rw = 0; mw = 0; mr = 0; fin = 1'b0;
        while (!fin && n <= 40) begin
            rw += int'(RegWrite);
            mw += int'(MemWrite);
            mr += int'(MemRead);
            if (done || illegal) begin
                fin = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
        got = sb.pop_front();
        check("done_kind", 32'(done), 32'(got.legal));
        check("illegal_kind", 32'(illegal), 32'(!got.legal));
        check("latency", 32'(n), 32'(got.lat));
        check("regwrite_pulses", 32'(rw), 32'(got.reg_wr));
        check("memwrite_pulses", 32'(mw), 32'(got.mem_wr));
        check("memread_cycles", 32'(mr), 32'(got.mem_rd));
        if (got.legal) begin
            check("ctrl", 32'({s_dst, s_src, s_alu, s_m2r}),
                  32'({got.reg_dst, got.alu_src, got.alu, got.m2r}));
            retired++;
        end
        if (got.mem_wr != 0) check("memwrite_with_done", 32'(MemWrite), 32'd1);
`ifdef MIPS_PERF_CNT_EN
        check("retiredCnt", 32'(retiredCnt), 32'(retired));
`endif
        if (hold) instrIn = nxt;
        tick();
        check("ready_after", 32'(instrReady), 32'd1);
        check("quiet_after", 32'({done, illegal, RegWrite, MemWrite}), 32'd0);
    endtask

    initial begin
        resetN     = 1'b0;
        instrValid = 1'b0;
        instrIn    = '0;
        repeat (2) tick();
        check("reset_flags", flags(), 32'd0);
        check("reset_aluctrl", 32'(ALUCtrl), 32'd2);
        check("reset_ir", instrOut, 32'd0);
        resetN = 1'b1;
        tick();
        check("ready_out_of_reset", 32'(instrReady), 32'd1);

        run(32'h00221820, 1'b0, '0);   // add $3,$1,$2
        run(32'h8C050004, 1'b0, '0);   // lw $5,4($0)
        run(32'hAC050008, 1'b0, '0);   // sw $5,8($0)
        run(32'hFC000000, 1'b0, '0);   // opcode 0x3F
        run(32'h20430005, 1'b0, '0);   // addi $3,$2,5
        run(32'h00221822, 1'b0, '0);   // sub
        run(32'h00221824, 1'b0, '0);   // and
        run(32'h00221825, 1'b0, '0);   // or
        run(32'h00221821, 1'b0, '0);   // addu: unsupported funct
        run(32'h00220020, 1'b0, '0);   // add $0,$1,$2 still writes

        // Reset three cycles while an lw sits in MEM: dropped, no pulses.
        instrIn    = 32'h8C050004;
        instrValid = 1'b1;
        sb.push_back(model(instrIn));
        tick();
        instrValid = 1'b0;
        repeat (2) tick();
        check("lw_in_mem", 32'(MemRead), 32'd1);
        resetN = 1'b0;
        void'(sb.pop_back());
        repeat (3) begin
            tick();
            check("midreset_flags", flags(), 32'd0);
            check("midreset_aluctrl", 32'(ALUCtrl), 32'd2);
            check("midreset_ir", instrOut, 32'd0);
        end
        resetN = 1'b1;
        tick();
        check("release_ready", 32'(instrReady), 32'd1);
        check("release_quiet", 32'({done, illegal, RegWrite, MemWrite}), 32'd0);

        // Back-to-back slt then nor with instrValid held high.
        run(32'h0022182A, 1'b1, 32'h00221827);
        run(32'h00221827, 1'b0, '0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef MIPS_PERF_CNT_EN
        check("retired_b2b", 32'(retiredCnt), 32'd2);
        check("cycleCnt", 32'(cycleCnt), 32'(live));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
